// File: rtl/pipeline24_result_collector.sv
// Result collector for the 24-permutation pack: grabs each pending result after a fixed latency,
// tags it with a sequence index, and buffers it in a 4-entry show-ahead FIFO toward the host.
module pipeline24_result_collector #(
  parameter int SUM_WIDTH    = 50,
  parameter int COUNT_WIDTH  = 15,
  parameter int GRAB_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   resultsAvailable,
  input  logic [SUM_WIDTH-1:0]   pcoeffSum,
  input  logic [COUNT_WIDTH-1:0] pcoeffCount,
  input  logic                   eccStatus,
  output logic                   grabResults,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [SUM_WIDTH-1:0]   outSum,
  output logic [COUNT_WIDTH-1:0] outCount,
  output logic [15:0]            outIndex,
  output logic                   outEcc,
  output logic                   eccSeen,
  output logic [15:0]            eccErrorCount,
  output logic [31:0]            resultsCollected
);

  typedef enum logic [1:0] {S_IDLE, S_GRAB, S_WAIT, S_CAPTURE} state_t;

  typedef struct packed {
    logic [SUM_WIDTH-1:0]   sum;
    logic [COUNT_WIDTH-1:0] count;
    logic                   ecc;
    logic [15:0]            idx;
  } entry_t;

  localparam logic [3:0] WAIT_LOAD = 4'(GRAB_LATENCY - 1);

  state_t      state_q;
  logic [3:0]  wait_cnt_q;
  logic        grab_q;

  entry_t      mem_q [4];
  entry_t      head_q, head_d, wr_entry;
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        push, pop;

  logic [15:0] seq_q, seq_d;
  logic        ecc_seen_q, ecc_seen_d;
  logic [15:0] ecc_cnt_q, ecc_cnt_d;
  logic [31:0] collected_q, collected_d;

  // The space check at IDLE guarantees the later CAPTURE write finds a free slot,
  // since only pops can happen while the grab is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      grab_q     <= 1'b0;
    end else begin
      grab_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (resultsAvailable && (count_q < 3'd4)) begin
            state_q <= S_GRAB;
            grab_q  <= 1'b1;
          end
        end
        S_GRAB: begin
          wait_cnt_q <= WAIT_LOAD;
          state_q    <= (GRAB_LATENCY == 1) ? S_CAPTURE : S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q <= 4'd1) state_q <= S_CAPTURE;
          else                    wait_cnt_q <= wait_cnt_q - 4'd1;
        end
        S_CAPTURE: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign push     = (state_q == S_CAPTURE);
  assign pop      = (count_q != 3'd0) && outReady;
  assign wr_entry = '{sum: pcoeffSum, count: pcoeffCount, ecc: eccStatus, idx: seq_q};

  // NOTE: every signal gets a default first, so no path through this block can infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + {1'b0, push};
    rd_ptr_d    = rd_ptr_q + {1'b0, pop};
    count_d     = count_q + {2'b00, push} - {2'b00, pop};
    head_d      = head_q;
    seq_d       = seq_q;
    ecc_seen_d  = ecc_seen_q;
    ecc_cnt_d   = ecc_cnt_q;
    collected_d = collected_q;

    // Head register keeps the last head value once the FIFO drains.
    if (count_d != 3'd0) begin
      if ((count_q - {2'b00, pop}) == 3'd0) head_d = wr_entry;
      else                                  head_d = mem_q[rd_ptr_d];
    end

    if (push) begin
      seq_d       = seq_q + 16'd1;
      collected_d = collected_q + 32'd1;
      if (eccStatus) begin
        ecc_seen_d = 1'b1;
        if (ecc_cnt_q != 16'hFFFF) ecc_cnt_d = ecc_cnt_q + 16'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      seq_q       <= '0;
      ecc_seen_q  <= 1'b0;
      ecc_cnt_q   <= '0;
      collected_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      seq_q       <= seq_d;
      ecc_seen_q  <= ecc_seen_d;
      ecc_cnt_q   <= ecc_cnt_d;
      collected_q <= collected_d;
    end
  end

  // NOTE: the storage array has no reset; only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign grabResults      = grab_q;
  assign outValid         = (count_q != 3'd0);
  assign outSum           = head_q.sum;
  assign outCount         = head_q.count;
  assign outIndex         = head_q.idx;
  assign outEcc           = head_q.ecc;
  assign eccSeen          = ecc_seen_q;
  assign eccErrorCount    = ecc_cnt_q;
  assign resultsCollected = collected_q;

endmodule

// File: tb/tb_pipeline24_result_collector.sv
// Directed bench for pipeline24_result_collector: grab timing, back-pressure, push/pop overlap,
// ECC statistics, index wrap and reset during an in-flight grab.
module tb_pipeline24_result_collector;
  localparam int SW = 50;
  localparam int CW = 15;
  localparam int GL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          resultsAvailable = 1'b0;
  logic [SW-1:0] pcoeffSum = '0;
  logic [CW-1:0] pcoeffCount = '0;
  logic          eccStatus = 1'b0;
  logic          outReady = 1'b0;
  logic          grabResults, outValid, outEcc, eccSeen;
  logic [SW-1:0] outSum;
  logic [CW-1:0] outCount;
  logic [15:0]   outIndex, eccErrorCount;
  logic [31:0]   resultsCollected;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  pipeline24_result_collector #(.SUM_WIDTH(SW), .COUNT_WIDTH(CW), .GRAB_LATENCY(GL)) dut (
    .clk(clk), .rst(rst), .resultsAvailable(resultsAvailable), .pcoeffSum(pcoeffSum),
    .pcoeffCount(pcoeffCount), .eccStatus(eccStatus), .grabResults(grabResults),
    .outValid(outValid), .outReady(outReady), .outSum(outSum), .outCount(outCount),
    .outIndex(outIndex), .outEcc(outEcc), .eccSeen(eccSeen), .eccErrorCount(eccErrorCount),
    .resultsCollected(resultsCollected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt;
    logic          ecc;
    logic [15:0]   idx;
    logic          seen;
    logic [15:0]   errs;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grab"},      64'(grabResults), 64'(0));
    check({tag, "_valid"},     64'(outValid), 64'(0));
    check({tag, "_sum"},       64'(outSum), 64'(0));
    check({tag, "_count"},     64'(outCount), 64'(0));
    check({tag, "_index"},     64'(outIndex), 64'(0));
    check({tag, "_ecc"},       64'(outEcc), 64'(0));
    check({tag, "_ecc_seen"},  64'(eccSeen), 64'(0));
    check({tag, "_ecc_errs"},  64'(eccErrorCount), 64'(0));
    check({tag, "_collected"}, 64'(resultsCollected), 64'(0));
  endtask

  // Requests one result, supplies its payload for the capture cycle, returns one cycle after capture.
  task automatic grab_one(input logic [SW-1:0] s, input logic [CW-1:0] c, input logic e,
                          input logic pop_in_capture);
    int waited = 0;
    resultsAvailable = 1'b1;
    do begin
      tick();
      waited++;
    end while (!grabResults && waited < 20);
    check("grab_seen", 64'(grabResults), 64'(1));
    resultsAvailable = 1'b0;
    pcoeffSum = s;
    pcoeffCount = c;
    eccStatus = e;
    repeat (GL) tick();
    if (pop_in_capture) outReady = 1'b1;
    tick();
    outReady = 1'b0;
  endtask

  task automatic pop_head(input string name, input logic [15:0] idx, input logic [SW-1:0] s,
                          input logic [CW-1:0] c);
    check({name, "_valid"}, 64'(outValid), 64'(1));
    check({name, "_index"}, 64'(outIndex), 64'(idx));
    check({name, "_sum"},   64'(outSum), 64'(s));
    check({name, "_count"}, 64'(outCount), 64'(c));
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   grab_cyc[8];
    int   ngrab = 0;
    int   waited;
    int   stray;
    vec_t tbl[4];

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Single result then back-pressure: ready held low, available held high from cycle 0.
    rst = 1'b1;
    resultsAvailable = 1'b1;
    pcoeffSum = SW'(50'h1234);
    pcoeffCount = CW'(7);
    cyc = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (grabResults) begin
        if (ngrab < 8) grab_cyc[ngrab] = cyc;
        pcoeffSum = 50'h1234 + 50'(16 * ngrab);
        pcoeffCount = CW'(7 + ngrab);
        ngrab++;
      end
      if (cyc == 3) check("single_valid_c3", 64'(outValid), 64'(0));
      if (cyc == 4) begin
        check("single_valid_c4", 64'(outValid), 64'(1));
        check("single_sum",      64'(outSum), 64'h1234);
        check("single_count",    64'(outCount), 64'(7));
        check("single_index",    64'(outIndex), 64'(0));
      end
    end
    check("full_grab_count", 64'(ngrab), 64'(4));
    for (int i = 0; i < 4; i++) check("full_grab_cycle", 64'(grab_cyc[i]), 64'(1 + 4 * i));
    check("full_head_index", 64'(outIndex), 64'(0));

    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    check("pop_one_index", 64'(outIndex), 64'(1));
    waited = 0;
    while (!grabResults && waited < 10) begin
      tick();
      waited++;
    end
    check("fifth_grab_cycle", 64'(cyc), 64'(26));
    resultsAvailable = 1'b0;
    pcoeffSum = 50'h1274;
    pcoeffCount = CW'(11);
    repeat (GL + 1) tick();
    for (int i = 1; i <= 4; i++)
      pop_head("drain_bp", 16'(i), 50'h1234 + 50'(16 * i), CW'(7 + i));
    check("drain_bp_empty", 64'(outValid), 64'(0));
    check("drain_bp_collected", 64'(resultsCollected), 64'(5));

    // Push and pop in the same cycle with two entries buffered.
    grab_one(50'hA0, 15'd1, 1'b0, 1'b0);
    grab_one(50'hA1, 15'd2, 1'b0, 1'b0);
    grab_one(50'hA2, 15'd3, 1'b0, 1'b1);
    pop_head("pushpop", 16'd6, 50'hA1, 15'd2);
    pop_head("pushpop", 16'd7, 50'hA2, 15'd3);
    check("pushpop_empty", 64'(outValid), 64'(0));

    // ECC statistics, table-driven.
    check("ecc_seen_before", 64'(eccSeen), 64'(0));
    tbl[0] = '{sum: 50'h3_0000_0001, cnt: 15'h7FFF, ecc: 1'b1, idx: 16'd8,  seen: 1'b1, errs: 16'd1};
    tbl[1] = '{sum: 50'h0,           cnt: 15'h0,    ecc: 1'b0, idx: 16'd9,  seen: 1'b1, errs: 16'd1};
    tbl[2] = '{sum: 50'h3_FFFF_FFFF_FFFF, cnt: 15'h1234, ecc: 1'b1, idx: 16'd10, seen: 1'b1, errs: 16'd2};
    tbl[3] = '{sum: 50'h5A5A,        cnt: 15'h2AAA, ecc: 1'b0, idx: 16'd11, seen: 1'b1, errs: 16'd2};
    for (int i = 0; i < 4; i++) begin
      grab_one(tbl[i].sum, tbl[i].cnt, tbl[i].ecc, 1'b0);
      check("ecc_seen", 64'(eccSeen), 64'(tbl[i].seen));
      check("ecc_errs", 64'(eccErrorCount), 64'(tbl[i].errs));
    end
    for (int i = 0; i < 4; i++) begin
      check("ecc_out", 64'(outEcc), 64'(tbl[i].ecc));
      pop_head("ecc_head", tbl[i].idx, tbl[i].sum, tbl[i].cnt);
    end
    check("ecc_collected", 64'(resultsCollected), 64'(12));

    // Preload the counters near the wrap point instead of running 65k captures.
    force dut.seq_q = 16'hFFFE;
    force dut.collected_q = 32'd65534;
    tick();
    release dut.seq_q;
    release dut.collected_q;
    tick();
    check("wrap_preload", 64'(resultsCollected), 64'(65534));
    grab_one(50'hF0, 15'd1, 1'b0, 1'b0);
    grab_one(50'hF1, 15'd2, 1'b0, 1'b0);
    grab_one(50'hF2, 15'd3, 1'b0, 1'b0);
    pop_head("wrap", 16'hFFFE, 50'hF0, 15'd1);
    pop_head("wrap", 16'hFFFF, 50'hF1, 15'd2);
    pop_head("wrap", 16'h0000, 50'hF2, 15'd3);
    check("wrap_collected", 64'(resultsCollected), 64'(65537));

    // Reset during WAIT with two entries buffered.
    grab_one(50'hB0, 15'd4, 1'b0, 1'b0);
    grab_one(50'hB1, 15'd5, 1'b1, 1'b0);
    check("pre_reset_valid", 64'(outValid), 64'(1));
    resultsAvailable = 1'b1;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!grabResults && waited < 20);
    resultsAvailable = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check_reset_outputs("midwait");
    tick();
    tick();
    rst = 1'b1;
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (grabResults) stray++;
    end
    check("no_stray_grab", 64'(stray), 64'(0));
    check("post_reset_empty", 64'(outValid), 64'(0));
    grab_one(50'h55, 15'd5, 1'b0, 1'b0);
    pop_head("post_reset", 16'd0, 50'h55, 15'd5);
    check("post_reset_collected", 64'(resultsCollected), 64'(1));
    check("post_reset_ecc_seen", 64'(eccSeen), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline24_result_collector.md
# pipeline24_result_collector

Sits directly downstream of the 24-permutation pack and drains its results. When the pack reports `resultsAvailable`, the block issues a single-cycle `grabResults`, waits the fixed grab latency, and captures `pcoeffSum`, `pcoeffCount` and `eccStatus`. Each capture is tagged with a 16-bit sequence index and buffered in a 4-entry FIFO with a valid/ready output toward the host-side result stream.

## Interface
- `SUM_WIDTH`, default 50: width of `pcoeffSum` (`PCOEFF_COUNT_BITWIDTH`+2+35).
- `COUNT_WIDTH`, default 15: width of `pcoeffCount` (`PCOEFF_COUNT_BITWIDTH`+2).
- `GRAB_LATENCY`, default 2: cycles from the `grabResults` cycle to the cycle in which result data is valid. Legal range 1..15.
- `clk` in 1: single clock; everything is synchronous to it.
- `rst` in 1: reset, **asynchronous, active-low**.
- `resultsAvailable` in 1: the pack holds a result.
- `pcoeffSum` in SUM_WIDTH: result sum from the pack.
- `pcoeffCount` in COUNT_WIDTH: result count from the pack.
- `eccStatus` in 1: ECC error level from the pack.
- `grabResults` out 1: registered one-cycle pulse that pops the pack's result.
- `outValid` out 1: FIFO head is valid.
- `outReady` in 1: consumer accepts the head on `outValid && outReady`.
- `outSum` out SUM_WIDTH, `outCount` out COUNT_WIDTH: head payload.
- `outIndex` out 16: sequence index of the head entry.
- `outEcc` out 1: `eccStatus` sampled with the head entry.
- `eccSeen` out 1: sticky; set by any captured entry with ecc=1.
- `eccErrorCount` out 16: number of captured entries with ecc=1, saturating at 0xFFFF.
- `resultsCollected` out 32: total captures, wraps modulo 2^32.

## Operation
- FSM states and transitions:
  - IDLE → GRAB when `resultsAvailable && fifoCount < 4`.
  - GRAB lasts exactly 1 cycle, with `grabResults`=1 in that cycle; then → WAIT.
  - WAIT counts GRAB_LATENCY−1 cycles (0 if GRAB_LATENCY=1); then → CAPTURE.
  - CAPTURE lasts 1 cycle. It writes {sum, count, ecc, seqIdx} into the FIFO, increments seqIdx (0xFFFF wraps to 0) and `resultsCollected`, and updates the ecc statistics. Then → IDLE.
- `grabResults` is high only in GRAB.
- `resultsAvailable` is ignored outside IDLE. This covers the stale-high window caused by upstream registering.
- Only one grab is ever in flight. The space check in IDLE guarantees the CAPTURE write never finds the FIFO full, because only pops can occur in between.
- FIFO: 4 entries, first-in first-out, show-ahead. The `out*` signals are driven from the head entry.
  - A push and a pop in the same cycle are both performed, and `fifoCount` is unchanged.
  - A pop while empty has no effect.
  - Payload outputs hold the last head value while `outValid`=0; the consumer must not rely on that value.
- ECC statistics:
  - `eccSeen` is cleared only by reset.
  - `eccErrorCount` stops at 0xFFFF.

## Timing
- Reset values (all asynchronous, `rst`=0):
  - FSM state = IDLE; `grabResults`=0; `outValid`=0; `fifoCount`=0; seqIdx=0.
  - `eccSeen`=0; `eccErrorCount`=0; `resultsCollected`=0.
  - `outSum`=0, `outCount`=0, `outIndex`=0, `outEcc`=0.
- Reset asserted mid-operation abandons any in-flight grab and discards FIFO contents. The pack must be reset in the same window.
- Latencies:
  - `resultsAvailable` sampled high in IDLE (cycle t) → `grabResults`=1 in cycle t+1.
  - Data is sampled at cycle t+1+GRAB_LATENCY (the CAPTURE cycle).
  - `outValid` rises in cycle t+2+GRAB_LATENCY if the FIFO was empty.
- Minimum spacing between `grabResults` pulses is GRAB_LATENCY+2 cycles. The default gives 4.
- `outValid` is not combinationally dependent on `outReady`.

## Test plan
- **Single result:** GRAB_LATENCY=2; hold `resultsAvailable`=1 from cycle 0; at cycle 3 drive sum=0x1234, count=7, ecc=0; hold `outReady`=0.
  - Required: exactly one `grabResults` pulse at cycle 1; `outValid` at cycle 4 with sum 0x1234, count 7, index 0.
- **Back-pressure / full:** hold `resultsAvailable`=1 and `outReady`=0.
  - Required: exactly 4 grabs at cycles 1, 5, 9 and 13, with indices 0..3; no 5th grab until one pop.
  - Then pop once: the 5th grab occurs, and the following capture gets index 4.
- **Simultaneous push and pop:** FIFO holds 2 entries and `outReady`=1 during a CAPTURE cycle.
  - Required: count stays 2, order is preserved, and indices remain contiguous.
- **ECC:** 3 captures with ecc=1,0,1.
  - Required: `eccSeen`=1 after the first; `eccErrorCount`=2; `outEcc` sequence 1,0,1.
- **Wrap-around:** force 65,537 captures with `outReady`=1.
  - Required: indices run …0xFFFF, 0x0000; `resultsCollected`=65537.
- **Reset mid-WAIT:** assert `rst`=0 during WAIT with 2 entries buffered.
  - Required: all outputs return to reset values immediately; after release, the first capture has index 0 and no stray `grabResults` pulse appears.
